snn_core: RTL and testbench
===========================

SNN_CORE -- requirements
Module: snn_core

Interface
REQ-001 Parameter F, default 48: number of input event channels (features).
REQ-002 Parameter N, default 96: number of LIF neurons.
REQ-003 Parameter Q, default 14: fractional bits of the leak coefficient.
REQ-004 Parameter ALPHA_Q14, default 15474: leak coefficient alpha, unsigned in Q0.Q (about 0.944).
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port event_vec, input, F bits: bit i high means an input spike on channel i this tick.
REQ-008 Port spikes_vec, output, N bits, registered: bit n high means neuron n fired this tick.
REQ-009 Internal array weights_rom[0:F*N-1], signed 16-bit, SHALL be hierarchically writable by name; entry i*N+n is the weight from channel i to neuron n.
REQ-010 Internal array vth_rom[0:N-1], signed 16-bit, SHALL be hierarchically writable by name; it holds the per-neuron threshold.
REQ-011 weights_rom and vth_rom SHALL NOT be modified by the module and SHALL NOT be cleared by reset.

Function
REQ-012 One tick is one clk rising edge; every neuron updates in parallel on each edge.
REQ-013 Each neuron holds signed 16-bit membrane state v[n].
REQ-014 Leak term: leak = (v[n] * ALPHA_Q14) >>> Q, computed with a signed 32-bit product and an arithmetic shift (floor toward negative infinity).
REQ-015 Input term: syn = sum over i of weights_rom[i*N+n] where event_vec[i]=1, accumulated in a signed 32-bit accumulator.
REQ-016 Candidate: u = leak + syn, in signed 32 bits, then clamped or wrapped to 16 bits per REQ-024 and REQ-025.
REQ-017 Fire rule: if u >= vth_rom[n] (signed compare), then spikes_vec[n] is set to 1 and v[n] is set to 0.
REQ-018 Otherwise spikes_vec[n] is set to 0 and v[n] is set to u.
REQ-019 Latency: event_vec sampled at edge k determines spikes_vec after edge k. Output is registered with one-edge latency and has no combinational path from input to output.
REQ-020 All-zero event_vec gives a pure leak step. Equality with the threshold fires.

Reset
REQ-021 While rstn=0, all v[n] SHALL be 0 and spikes_vec SHALL be all 0, asynchronously.
REQ-022 After release, the first edge performs a normal update starting from v=0.
REQ-023 Asserting reset mid-run discards all membrane state; the ROM contents persist.

Configuration
REQ-024 With macro SNN_SATURATE_EN defined, u SHALL saturate to the range [-32768, 32767] before the compare and the state write.
REQ-025 Without SNN_SATURATE_EN, u SHALL be truncated to its low 16 bits (two's-complement wrap) before the compare and the state write.

Verification
REQ-026 Setup W[0]=100, vth[0]=150, event bit0=1 for 2 ticks. Required: tick0 has no spike with v=100; tick1 has u=94+100=194, spike, and v becomes 0.
REQ-027 Leak only: v=100 with zero events. Required: v becomes 94, then 88; spikes stay 0 given vth[0]=150.
REQ-028 Negative floor: weight -100 applied once, then zero events. Required: v=-100, then v=-95.
REQ-029 Threshold equality: W=150, vth=150, one event. Required: spike on that tick and v becomes 0.
REQ-030 All 48 events high with all weights 32767 and vth=32767. Required with SNN_SATURATE_EN: spike for every n. Required without it: the wrapped value is compared.
REQ-031 Drive rstn low mid-run with v nonzero. Required: spikes_vec=0 immediately and v=0; after release, the sequence from REQ-026 reproduces identically.

Source files
------------

// File: rtl/snn_core.sv
// snn_core: a layer of N leaky integrate-and-fire neurons driven by F binary event channels.
// Latency: one clk edge. event_vec sampled at edge k sets spikes_vec and membrane state after edge k.
// Backpressure: none. Every neuron updates unconditionally on every edge.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   rstn       - asynchronous active-low reset; clears membrane state and spikes
//   event_vec  - [F-1:0] input spikes for this tick
//   spikes_vec - [N-1:0] registered output spikes
// Internal arrays weights_rom (entry i*N+n = weight channel i -> neuron n) and vth_rom
// (per-neuron threshold) are loaded hierarchically from outside. This module never writes
// them, and reset does not clear them.
// Build option: define SNN_SATURATE_EN to saturate the candidate to 16 bits. When it is
// undefined, the candidate wraps to its low 16 bits.
module snn_core #(
  parameter int F         = 48,
  parameter int N         = 96,
  parameter int Q         = 14,
  parameter int ALPHA_Q14 = 15474
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [F-1:0] event_vec,
  output logic [N-1:0] spikes_vec
);

  logic signed [15:0] weights_rom [0:F*N-1];
  logic signed [15:0] vth_rom     [0:N-1];

  logic signed [15:0] v     [0:N-1];
  logic signed [15:0] u_nxt [0:N-1];
  logic [N-1:0]       fire;

  localparam logic signed [31:0] ALPHA_S = 32'(ALPHA_Q14);

  for (genvar n = 0; n < N; n++) begin : g_neuron
    logic signed [31:0] syn;
    logic signed [31:0] leak;
    logic signed [31:0] u32;
    logic signed [15:0] u16;

    always_comb begin
      syn = '0;
      for (int i = 0; i < F; i++) begin
        if (event_vec[i]) syn = syn + 32'(weights_rom[i*N+n]);
      end
    end

    // The arithmetic shift floors toward negative infinity, so small negative v
    // leak toward -1 instead of toward 0.
    assign leak = (32'(v[n]) * ALPHA_S) >>> Q;
    assign u32  = leak + syn;

`ifdef SNN_SATURATE_EN
    always_comb begin
      if (u32 > 32'sd32767)       u16 = 16'sh7fff;
      else if (u32 < -32'sd32768) u16 = -16'sd32768;
      else                        u16 = u32[15:0];
    end
`else
    assign u16 = u32[15:0];
`endif

    assign u_nxt[n] = u16;
    assign fire[n]  = (u16 >= vth_rom[n]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spikes_vec <= '0;
      for (int n = 0; n < N; n++) v[n] <= '0;
    end else begin
      spikes_vec <= fire;
      for (int n = 0; n < N; n++) v[n] <= fire[n] ? 16'sd0 : u_nxt[n];
    end
  end

endmodule

// File: tb/tb_snn_core.sv
module tb_snn_core;
  localparam int F     = 48;
  localparam int N     = 96;
  localparam int Q     = 14;
  localparam int ALPHA = 15474;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [F-1:0] event_vec = '0;
  logic [N-1:0] spikes_vec;

  int total = 0;
  int bad   = 0;

  // Shadow copies of the ROM contents and the reference membrane state.
  int wm  [0:F*N-1];
  int thm [0:N-1];
  int mv  [0:N-1];
  logic [N-1:0] exp_spk = '0;

  snn_core #(.F(F), .N(N), .Q(Q), .ALPHA_Q14(ALPHA)) dut (
    .clk(clk), .rstn(rstn), .event_vec(event_vec), .spikes_vec(spikes_vec)
  );

  always #5 clk = ~clk;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int fit16(input int u);
    int r;
`ifdef SNN_SATURATE_EN
    if (u > 32767) r = 32767;
    else if (u < -32768) r = -32768;
    else r = u;
`else
    r = u & 32'h0000ffff;
    if (r >= 32768) r = r - 65536;
`endif
    return r;
  endfunction

  task automatic set_w(input int idx, input int val);
    wm[idx] = val;
    dut.weights_rom[idx] = 16'(val);
  endtask

  task automatic set_th(input int n, input int val);
    thm[n] = val;
    dut.vth_rom[n] = 16'(val);
  endtask

  task automatic model_step(input logic [F-1:0] ev);
    int syn, leak, u;
    for (int n = 0; n < N; n++) begin
      syn = 0;
      for (int i = 0; i < F; i++) if (ev[i]) syn += wm[i*N+n];
      leak = floor_div(mv[n] * ALPHA, 1 << Q);
      u = fit16(leak + syn);
      if (u >= thm[n]) begin
        exp_spk[n] = 1'b1;
        mv[n] = 0;
      end else begin
        exp_spk[n] = 1'b0;
        mv[n] = u;
      end
    end
  endtask

  task automatic check_model(input string name);
    int nbad, first;
    total++;
    if (spikes_vec !== exp_spk) begin
      bad++;
      $display("FAIL %s spikes: got %h want %h", name, spikes_vec, exp_spk);
    end
    total++;
    nbad = 0;
    first = -1;
    for (int n = 0; n < N; n++) begin
      if (int'($signed(dut.v[n])) != mv[n]) begin
        nbad++;
        if (first < 0) first = n;
      end
    end
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s v[%0d]: got %0d want %0d (%0d neurons off)", name, first,
               $signed(dut.v[first]), mv[first], nbad);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick(input logic [F-1:0] ev);
    event_vec = ev;
    @(posedge clk);
    #1;
    model_step(ev);
    check_model("tick");
  endtask

  // Asynchronous reset between edges. Outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    for (int n = 0; n < N; n++) mv[n] = 0;
    exp_spk = '0;
    check_model("reset");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic clear_rom(input int th);
    for (int k = 0; k < F*N; k++) set_w(k, 0);
    for (int n = 0; n < N; n++) set_th(n, th);
  endtask

  logic [F-1:0] ev_one;
  logic [F-1:0] ev_all;
  logic [F-1:0] ev_r;

  initial begin
    ev_one = '0;
    ev_one[0] = 1'b1;
    ev_all = '1;
    for (int n = 0; n < N; n++) mv[n] = 0;
    clear_rom(150);
    set_w(0, 100);

    #1;
    check_model("reset_state");
    @(negedge clk);
    rstn = 1'b1;

    // Integrate then fire: 100, then 94 + 100 = 194 crosses 150.
    tick(ev_one);
    check_lit("seq_t0_v", int'($signed(dut.v[0])), 100);
    check_lit("seq_t0_spk", int'(spikes_vec[0]), 0);
    tick(ev_one);
    check_lit("seq_t1_spk", int'(spikes_vec[0]), 1);
    check_lit("seq_t1_v", int'($signed(dut.v[0])), 0);

    // Leak only.
    tick(ev_one);
    tick('0);
    check_lit("leak_94", int'($signed(dut.v[0])), 94);
    tick('0);
    check_lit("leak_88", int'($signed(dut.v[0])), 88);
    check_lit("leak_nospk", int'(spikes_vec[0]), 0);

    // Mid-run reset with nonzero v, then the fire sequence must repeat exactly.
    do_reset();
    tick(ev_one);
    check_lit("rst_t0_v", int'($signed(dut.v[0])), 100);
    tick(ev_one);
    check_lit("rst_t1_spk", int'(spikes_vec[0]), 1);

    // Negative values floor toward minus infinity.
    do_reset();
    set_w(0, -100);
    tick(ev_one);
    check_lit("neg_v", int'($signed(dut.v[0])), -100);
    tick('0);
    check_lit("neg_floor", int'($signed(dut.v[0])), -95);

    // Equality with the threshold fires.
    do_reset();
    set_w(0, 150);
    tick(ev_one);
    check_lit("eq_spk", int'(spikes_vec[0]), 1);
    check_lit("eq_v", int'($signed(dut.v[0])), 0);

    // Randomized weights, thresholds and events, with an occasional reset.
    for (int k = 0; k < F*N; k++) set_w(k, $urandom_range(0, 4000) - 1500);
    for (int n = 0; n < N; n++) set_th(n, $urandom_range(0, 6000) - 500);
    do_reset();
    for (int t = 0; t < 300; t++) begin
      ev_r = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ev_r = '0;
      if ($urandom_range(0, 3) == 0) ev_r = ev_r & {$urandom, $urandom};
      tick(ev_r);
      if ($urandom_range(0, 60) == 0) do_reset();
    end

    // Overflow corner: all channels at maximum weight.
    clear_rom(32767);
    for (int k = 0; k < F*N; k++) set_w(k, 32767);
    do_reset();
    tick(ev_all);
`ifdef SNN_SATURATE_EN
    check_lit("ovf_all_spk", int'(&spikes_vec), 1);
`else
    // 48*32767 = 0x17FFD0 wraps to -48.
    check_lit("ovf_wrap_spk", int'(|spikes_vec), 0);
    check_lit("ovf_wrap_v", int'($signed(dut.v[N-1])), -48);
`endif
    tick(ev_all);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
